// File: rtl/maxpool2x2.sv
// rtl/maxpool2x2.sv - 2x2 stride-2 signed max-pool over parallel per-channel feature beats
module maxpool2x2 #(
   parameter int NUM_CH     = 6,
   parameter int DATA_WIDTH = 16,
   parameter int IN_WIDTH   = 24,
   parameter int IN_HEIGHT  = 24
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_valid,
   input  logic signed [DATA_WIDTH-1:0] i_features [NUM_CH],
   output logic                         o_valid,
   output logic signed [DATA_WIDTH-1:0] o_features [NUM_CH],
   output logic                         o_last
);

   localparam int HALF_W = IN_WIDTH / 2;
   localparam int HW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
   localparam int CW     = HW + 1;
   localparam int RW     = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

   typedef enum logic {EVEN_ROW, ODD_ROW} phase_t;

   phase_t                         state_q, state_d;
   logic [CW-1:0]                  col_q, col_d;
   logic [RW-1:0]                  row_q, row_d;
   logic signed [DATA_WIDTH-1:0]   h_q [NUM_CH];
   logic signed [DATA_WIDTH-1:0]   h_d [NUM_CH];
   logic                           o_valid_q, o_valid_d;
   logic                           o_last_q, o_last_d;
   logic signed [DATA_WIDTH-1:0]   o_feat_q [NUM_CH];
   logic signed [DATA_WIDTH-1:0]   o_feat_d [NUM_CH];
   logic signed [DATA_WIDTH-1:0]   rb_q [NUM_CH][HALF_W];
   logic signed [DATA_WIDTH-1:0]   pair [NUM_CH];
   logic                           rb_we;
   logic [HW-1:0]                  half_col;
   logic                           col_last, row_last;

   assign half_col = col_q[CW-1:1];
   assign col_last = (col_q == COL_LAST);
   assign row_last = (row_q == ROW_LAST);

   // Horizontal max of the held even-column pixel and the current odd-column pixel.
   always_comb begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
         pair[ch] = (i_features[ch] > h_q[ch]) ? i_features[ch] : h_q[ch];
      end
   end

   always_comb begin
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      h_d       = h_q;
      o_valid_d = 1'b0;
      o_last_d  = 1'b0;
      o_feat_d  = o_feat_q;
      rb_we     = 1'b0;
      if (i_valid) begin
         if (col_last) begin
            col_d   = '0;
            state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
            row_d   = row_last ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
         if (!col_q[0]) begin
            h_d = i_features;
         end else if (state_q == EVEN_ROW) begin
            rb_we = 1'b1;
         end else begin
            o_valid_d = 1'b1;
            o_last_d  = row_last && col_last;
            for (int ch = 0; ch < NUM_CH; ch++) begin
               o_feat_d[ch] = (rb_q[ch][half_col] > pair[ch]) ? rb_q[ch][half_col] : pair[ch];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= EVEN_ROW;
         col_q     <= '0;
         row_q     <= '0;
         o_valid_q <= 1'b0;
         o_last_q  <= 1'b0;
         for (int ch = 0; ch < NUM_CH; ch++) begin
            h_q[ch]      <= '0;
            o_feat_q[ch] <= '0;
         end
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         o_valid_q <= o_valid_d;
         o_last_q  <= o_last_d;
         h_q       <= h_d;
         o_feat_q  <= o_feat_d;
      end
   end

   // Row buffer needs no reset: each entry is written on an even row before its odd-row read.
   always_ff @(posedge clk) begin
      if (rb_we) begin
         for (int ch = 0; ch < NUM_CH; ch++) begin
            rb_q[ch][half_col] <= pair[ch];
         end
      end
   end

   assign o_valid    = o_valid_q;
   assign o_last     = o_last_q;
   assign o_features = o_feat_q;

endmodule

// File: tb/tb_maxpool2x2.sv
// tb/tb_maxpool2x2.sv - scoreboard bench for maxpool2x2 against a frame-level window-max model
module tb_maxpool2x2;

   localparam int NUM_CH = 6;
   localparam int DW     = 16;
   localparam int W      = 24;
   localparam int H      = 24;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 i_valid;
   logic signed [DW-1:0] i_features [NUM_CH];
   logic                 o_valid;
   logic signed [DW-1:0] o_features [NUM_CH];
   logic                 o_last;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [NUM_CH*DW-1:0] exp_f [$];
   logic                 exp_l [$];
   int                   exp_c [$];

   int pix [NUM_CH][H][W];

   maxpool2x2 #(
      .NUM_CH(NUM_CH), .DATA_WIDTH(DW), .IN_WIDTH(W), .IN_HEIGHT(H)
   ) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_features(i_features),
      .o_valid(o_valid), .o_features(o_features), .o_last(o_last)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compares every presented pulse against the head of the scoreboard.
   always @(negedge clk) begin
      logic [NUM_CH*DW-1:0] got, want;
      logic wl;
      int wc;
      for (int ch = 0; ch < NUM_CH; ch++) got[ch*DW +: DW] = o_features[ch];
      if (o_last && !o_valid) begin
         total++; bad++;
         $display("FAIL last_without_valid: got o_last=1 o_valid=0 want o_last=0 at cycle %0d", cyc);
      end
      if (o_valid) begin
         if (exp_f.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_pulse: got o_valid=1 want no pulse at cycle %0d", cyc);
         end else begin
            want = exp_f.pop_front();
            wl   = exp_l.pop_front();
            wc   = exp_c.pop_front();
            total++;
            if (got !== want) begin
               bad++;
               $display("FAIL features: got %h want %h at cycle %0d", got, want, cyc);
            end
            total++;
            if (o_last !== wl) begin
               bad++;
               $display("FAIL o_last: got %0b want %0b at cycle %0d", o_last, wl, cyc);
            end
            total++;
            if (cyc != wc) begin
               bad++;
               $display("FAIL latency: pulse at cycle %0d want cycle %0d", cyc, wc);
            end
         end
      end
   end

   function automatic int gen_pix(input int mode, input int ch, input int r, input int c, input int offset);
      int win, pos;
      logic [DW-1:0] t;
      case (mode)
         0: return r * W + c + offset;
         1: begin
            win = (r / 2) * (W / 2) + c / 2;
            pos = win % 4;
            if (((r % 2) * 2 + (c % 2)) == pos) return (ch == 5) ? 32767 : -1;
            return (ch == 5) ? -32768 : -5;
         end
         2: return ch * 1000 - (r * W + c);
         default: begin
            t = DW'($urandom);
            return int'($signed(t));
         end
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         i_valid = 1'b0;
      end
   endtask

   task automatic run_frame(input int mode, input int gap_pct, input int offset,
                            input int stop_r, input int stop_c);
      logic [NUM_CH*DW-1:0] v;
      int m;
      for (int ch = 0; ch < NUM_CH; ch++)
         for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
               pix[ch][r][c] = gen_pix(mode, ch, r, c, offset);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            if (gap_pct > 0 && $urandom_range(99, 0) < gap_pct)
               idle($urandom_range(5, 1));
            @(posedge clk); #1;
            i_valid = 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) i_features[ch] = DW'(pix[ch][r][c]);
            if ((r % 2 == 1) && (c % 2 == 1)) begin
               for (int ch = 0; ch < NUM_CH; ch++) begin
                  m = pix[ch][r-1][c-1];
                  if (pix[ch][r-1][c] > m) m = pix[ch][r-1][c];
                  if (pix[ch][r][c-1] > m) m = pix[ch][r][c-1];
                  if (pix[ch][r][c]   > m) m = pix[ch][r][c];
                  v[ch*DW +: DW] = DW'(m);
               end
               exp_f.push_back(v);
               exp_l.push_back((r == H - 1) && (c == W - 1));
               exp_c.push_back(cyc + 1);
            end
            if (r == stop_r && c == stop_c) begin
               idle(1);
               return;
            end
         end
      end
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (exp_f.size() != 0 && n < 20) begin
         @(posedge clk); #1;
         i_valid = 1'b0;
         n++;
      end
      total++;
      if (exp_f.size() != 0) begin
         bad++;
         $display("FAIL drain_%s: %0d pulses still outstanding, want 0", name, exp_f.size());
         exp_f.delete(); exp_l.delete(); exp_c.delete();
      end
   endtask

   task automatic check_reset_outputs(input string name);
      @(negedge clk);
      total++;
      if (o_valid !== 1'b0 || o_last !== 1'b0) begin
         bad++;
         $display("FAIL %s_flags: got valid=%0b last=%0b want 0 0", name, o_valid, o_last);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
         total++;
         if (o_features[ch] !== '0) begin
            bad++;
            $display("FAIL %s_feat%0d: got %0d want 0", name, ch, o_features[ch]);
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      i_valid = 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) i_features[ch] = '0;
      check_reset_outputs("reset");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run_frame(0, 0, 0, -1, -1);
      drain("ramp");
      run_frame(1, 0, 0, -1, -1);
      drain("signed");
      run_frame(2, 0, 0, -1, -1);
      drain("chan_indep");
      run_frame(0, 20, 0, -1, -1);
      drain("gapped");

      run_frame(0, 0, 0, 7, 13);
      drain("partial");
      @(posedge clk); #1;
      rst = 1'b1;
      i_valid = 1'b1;
      check_reset_outputs("midreset");
      @(posedge clk); #1;
      i_valid = 1'b0;
      rst = 1'b0;
      run_frame(0, 0, 0, -1, -1);
      drain("after_reset");

      run_frame(0, 0, 0, -1, -1);
      run_frame(0, 0, 1000, -1, -1);
      drain("back_to_back");

      run_frame(3, 15, 0, -1, -1);
      drain("random");
      idle(5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/maxpool2x2.md
# maxpool2x2

Two-by-two, stride-two max-pooling stage that sits directly downstream of the multi-filter convolution stage. It consumes the conv stage's parallel per-filter feature beats in raster order and emits one pooled beat per 2x2 window. Each channel is reduced independently, using signed comparison. For the default 24x24, 6-channel conv output it produces a 12x12, 6-channel pooled map with a last-beat marker for each frame.

## Interface
- NUM_CH, 6, number of parallel feature channels (conv filters)
- DATA_WIDTH, 16, signed width of each feature
- IN_WIDTH, 24, input frame width in pixels; must be even and ≥2
- IN_HEIGHT, 24, input frame height in pixels; must be even and ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  input beat valid; one pixel for all channels per asserted cycle
- i_features  in  NUM_CH x DATA_WIDTH (signed, unpacked array)  per-channel input feature
- o_valid  out  1  single-cycle pulse marking a pooled output beat
- o_features  out  NUM_CH x DATA_WIDTH (signed, unpacked array)  per-channel pooled feature
- o_last  out  1  high together with o_valid on the final pooled beat of a frame

## Operation
- No backpressure. Every cycle with i_valid=1 is accepted. Cycles with i_valid=0 change no state and may occur anywhere, including mid-row.
- Column counter col counts 0..IN_WIDTH-1 and row counter row counts 0..IN_HEIGHT-1. Both advance only on accepted beats.
- col wraps to 0 after IN_WIDTH-1 and row increments at that point. After (IN_HEIGHT-1, IN_WIDTH-1) both counters return to 0, so the next beat is pixel (0,0) of the next frame.
- Row-phase FSM has two states:
  - EVEN_ROW (reset state).
  - ODD_ROW.
  - The FSM toggles on every accepted beat with col = IN_WIDTH-1.
- Even column, any row: store the input in per-channel horizontal hold register h[ch].
- Odd column: compute pair[ch] = signed max(h[ch], i_features[ch]).
  - In EVEN_ROW: write pair into row buffer rb[ch][col>>1]. The row buffer has depth IN_WIDTH/2 per channel.
  - In ODD_ROW: register o_features[ch] = signed max(rb[ch][col>>1], pair[ch]) and pulse o_valid.
  - In ODD_ROW, o_last = 1 iff row = IN_HEIGHT-1 and col = IN_WIDTH-1.
- All comparisons are signed two's-complement at full DATA_WIDTH. There is no width growth, rounding or saturation. Equal values produce that value.
- Exactly (IN_WIDTH/2)*(IN_HEIGHT/2) o_valid pulses occur per frame (144 at the defaults). Pooled beats come out in raster order of the output map.
- Reset values:
  - o_valid = 0, o_last = 0, o_features = 0.
  - col = 0, row = 0, FSM = EVEN_ROW, h = 0.
  - rb is not reset. Every entry is written in EVEN_ROW before it is read in ODD_ROW.
- Reset mid-frame: the partial frame is discarded and no output pulse is produced from it. The first accepted beat after reset release is pixel (0,0).

## Timing
- Latency: o_valid and o_features appear on the clock edge that accepts pixel (odd row, odd col). They are visible in the following cycle, one cycle after the input is presented.
- o_valid and o_last are high for exactly one cycle per pooled beat, even when the next input cycle is idle.
- o_features holds its last value between pulses.
- Peak output rate is one pulse per two accepted beats, within odd rows only. Back-to-back frames need no idle cycles.
- rst asserted asynchronously forces all registered outputs to reset values immediately. Deassertion is synchronous to clk by the system reset bridge.

## Test plan
- Ramp frame, gapless: every channel = row*24+col → 144 pulses; output (r,c) = (2r+1)*24+2c+1 (first 25, last 575); o_last only on pulse 144.
- Signed compare: all pixels -5, with one pixel per window = -1 at a rotating window position; ch5 constant -32768 with one pixel per window = 32767 → ch0-4 output -1 and ch5 output 32767 on every pulse.
- Channel independence: ch k = k*1000 - (row*24+col) → ch k output (r,c) = k*1000 - (2r*24+2c) (the window's top-left is the maximum).
- Gapped input: ramp frame with i_valid randomly low ~40% of cycles, including runs of 5 → identical 144-value sequence; each pulse exactly one cycle after its completing beat.
- Reset mid-frame: assert rst after pixel (7,13), then a full ramp frame → no pulse during or after reset until (1,1) of the new frame; all 144 outputs match the clean-frame case.
- Back-to-back frames: two ramp frames, second offset by +1000, with no gap → 288 pulses, o_last on pulses 144 and 288, second frame values = first + 1000.
